// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: receives PS/2 keyboard frames and decodes set-2 scancodes
// into key events, handling the E0 (extended), F0 (break) and E1 (Pause)
// prefixes.
//
// Ports
//   clk        system clock, the only clock in the block
//   reset_n    asynchronous active-low reset
//   ps2_clk    keyboard clock line (asynchronous to clk)
//   ps2_data   keyboard data line (asynchronous to clk)
//   ps2_key    [7:0] scancode, [8] extended, [9] 1=make/0=break, [10] event toggle
//   key_strobe one-cycle pulse when ps2_key updates
//   frame_err  one-cycle pulse on parity/stop error or timeout abort
//
// Receiver states
//   state    | meaning
//   S_IDLE   | waiting for a start bit (sampled 0); sampled 1s are ignored
//   S_DATA   | shifting in 8 data bits, LSB first
//   S_PARITY | capturing the odd-parity bit
//   S_STOP   | checking the stop bit, then decoding the byte
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_q, fall_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [10:0]   key_q, key_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;

  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_d     = filt_q;
    filt_cnt_d = filt_cnt_q;
    fall_d     = 1'b0;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    skip_d     = skip_q;
    to_cnt_d   = to_cnt_q;
    key_d      = key_q;
    strobe_d   = 1'b0;
    err_d      = 1'b0;

    // Glitch filter: the counter tracks consecutive samples that differ from
    // the filtered level and never exceeds FILT_LAST, so it cannot wrap.
    if (clk_s2_q == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q >= FILT_LAST) begin
      filt_d     = clk_s2_q;
      filt_cnt_d = '0;
      fall_d     = ~clk_s2_q;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end

    if (state_q == S_IDLE) to_cnt_d = '0;

    if (fall_q) begin
      to_cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!dat_s2_q || !(^{shift_q, par_q})) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else if (shift_q == 8'hE1) begin
            skip_d = 3'd7;
          end else begin
            key_d    = {~key_q[10], ~brk_q, ext_q, shift_q};
            strobe_d = 1'b1;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // Abort a stalled frame; prefix flags survive so a resent byte still
      // pairs with its prefix.
      if (to_cnt_q >= TO_LAST) begin
        err_d     = 1'b1;
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
      to_cnt_q   <= '0;
      key_q      <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
      to_cnt_q   <= to_cnt_d;
      key_q      <= key_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
    end
  end

  assign ps2_key    = key_q;
  assign key_strobe = strobe_q;
  assign frame_err  = err_q;

endmodule
